// File: rtl/decode_regread.sv
// Decode / register-read stage: splits the instruction word, reads operands from a
// 16-entry register file, and interlocks read-after-write hazards with a busy scoreboard.
module decode_regread #(
   parameter int LEN_INSN    = 32,
   parameter int LEN_OPECODE = 7,
   parameter int LEN_IMMF    = 1,
   parameter int LEN_CC      = 4,
   parameter int LEN_REG     = 32,
   parameter int LEN_IMM_EX  = 16,
   parameter int NUM_REGS    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid_i,
   output logic                   stall_o,
   input  logic [LEN_INSN-1:0]    insn_i,
   output logic                   valid_o,
   input  logic                   stall_i,
   output logic [LEN_OPECODE-1:0] opecode,
   output logic [LEN_IMMF-1:0]    immf,
   output logic [LEN_CC-1:0]      cc,
   output logic [3:0]             rd_addr,
   output logic [LEN_REG-1:0]     data_rd,
   output logic [LEN_REG-1:0]     data_rs,
   output logic [LEN_IMM_EX-1:0]  imm_ex,
   input  logic                   wb_we,
   input  logic [3:0]             wb_addr,
   input  logic [LEN_REG-1:0]     wb_data,
   output logic                   halted
);

   localparam logic [LEN_OPECODE-1:0] OP_CMP = 7'b000_0100;
   localparam logic [LEN_OPECODE-1:0] OP_LD  = 7'b001_1000;
   localparam logic [LEN_OPECODE-1:0] OP_NOP = 7'b111_1110;
   localparam logic [LEN_OPECODE-1:0] OP_HLT = 7'b111_1111;

   // Opcodes whose result lands in rd and therefore mark it busy.
   function automatic logic writes_rd_f(input logic [LEN_OPECODE-1:0] op);
      logic w;
      w = 1'b0;
      if ((op[6:4] == 3'b000) && (op != OP_CMP)) begin
         w = 1'b1;
      end else if (op[6:3] == 4'b0010) begin
         w = 1'b1;
      end else if (op == OP_LD) begin
         w = 1'b1;
      end else begin
         w = 1'b0;
      end
      return w;
   endfunction

   function automatic logic reads_rd_f(input logic [LEN_OPECODE-1:0] op);
      return (op != OP_NOP) && (op != OP_HLT);
   endfunction

   logic [LEN_REG-1:0]     regs_r [NUM_REGS];
   logic [NUM_REGS-1:0]    busy_r;
   logic [NUM_REGS-1:0]    busy_nxt_s;

   logic [LEN_OPECODE-1:0] op_s;
   logic [LEN_IMMF-1:0]    immf_s;
   logic [LEN_CC-1:0]      cc_s;
   logic [3:0]             rd_s;
   logic [3:0]             rs_s;
   logic [LEN_IMM_EX-1:0]  imm_s;
   logic                   reads_rd_s;
   logic                   reads_rs_s;
   logic                   writes_rd_s;
   logic                   hit_rd_s;
   logic                   hit_rs_s;
   logic                   hazard_s;
   logic                   accept_s;
   logic [LEN_REG-1:0]     rd_val_s;
   logic [LEN_REG-1:0]     rs_val_s;

   assign op_s   = insn_i[31:25];
   assign immf_s = insn_i[24:24];
   assign cc_s   = insn_i[23:20];
   assign rd_s   = insn_i[19:16];
   assign rs_s   = insn_i[15:12];
   assign imm_s  = insn_i[15:0];

   assign writes_rd_s = writes_rd_f(op_s);
   assign reads_rd_s  = reads_rd_f(op_s);
   assign reads_rs_s  = reads_rd_s & (immf_s == 1'b0);

   // A writeback landing this cycle on a busy register resolves the hazard immediately.
   assign hit_rd_s = reads_rd_s & busy_r[rd_s] & ~(wb_we & (wb_addr == rd_s));
   assign hit_rs_s = reads_rs_s & busy_r[rs_s] & ~(wb_we & (wb_addr == rs_s));
   assign hazard_s = valid_i & (hit_rd_s | hit_rs_s);

   assign stall_o  = stall_i | hazard_s | halted;
   assign accept_s = valid_i & ~stall_o;

   // Operand read with writeback bypass; rs is zeroed for immediate forms.
   always_comb begin
      rd_val_s = regs_r[rd_s];
      rs_val_s = regs_r[rs_s];
      if (wb_we && (wb_addr == rd_s)) begin
         rd_val_s = wb_data;
      end else begin
         rd_val_s = regs_r[rd_s];
      end
      if (immf_s != 1'b0) begin
         rs_val_s = '0;
      end else if (wb_we && (wb_addr == rs_s)) begin
         rs_val_s = wb_data;
      end else begin
         rs_val_s = regs_r[rs_s];
      end
   end

   // Scoreboard next state: the set is applied after the clear so it wins on a collision.
   always_comb begin
      busy_nxt_s = busy_r;
      if (wb_we) begin
         busy_nxt_s[wb_addr] = 1'b0;
      end else begin
         busy_nxt_s = busy_r;
      end
      if (accept_s && writes_rd_s) begin
         busy_nxt_s[rd_s] = 1'b1;
      end else begin
         busy_nxt_s[rd_s] = busy_nxt_s[rd_s];
      end
   end

   // Busy scoreboard register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r <= '0;
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   // Register-file write port, independent of both stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (wb_we) begin
         regs_r[wb_addr] <= wb_data;
      end
   end

   // Output pipeline register; a downstream stall freezes everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_o <= 1'b0;
         halted  <= 1'b0;
         opecode <= '0;
         immf    <= '0;
         cc      <= '0;
         rd_addr <= 4'd0;
         data_rd <= '0;
         data_rs <= '0;
         imm_ex  <= '0;
      end else if (!stall_i) begin
         valid_o <= accept_s;
         if (accept_s) begin
            opecode <= op_s;
            immf    <= immf_s;
            cc      <= cc_s;
            rd_addr <= rd_s;
            data_rd <= rd_val_s;
            data_rs <= rs_val_s;
            imm_ex  <= imm_s;
            if (op_s == OP_HLT) begin
               halted <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_decode_regread.sv
// Directed bench for decode_regread: a vector table for the single-issue flow plus
// hand sequences for downstream stall, halt and asynchronous reset.
module tb_decode_regread;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic        stall_o;
   logic [31:0] insn_i;
   logic        valid_o;
   logic        stall_i;
   logic [6:0]  opecode;
   logic [0:0]  immf;
   logic [3:0]  cc;
   logic [3:0]  rd_addr;
   logic [31:0] data_rd;
   logic [31:0] data_rs;
   logic [15:0] imm_ex;
   logic        wb_we;
   logic [3:0]  wb_addr;
   logic [31:0] wb_data;
   logic        halted;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   decode_regread dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .stall_o(stall_o), .insn_i(insn_i),
      .valid_o(valid_o), .stall_i(stall_i), .opecode(opecode), .immf(immf), .cc(cc),
      .rd_addr(rd_addr), .data_rd(data_rd), .data_rs(data_rs), .imm_ex(imm_ex),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .halted(halted)
   );

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic        v;
      logic [31:0] insn;
      logic        e_stall;
      logic        e_valid;
      logic [6:0]  e_op;
      logic [3:0]  e_cc;
      logic [3:0]  e_rd;
      logic [31:0] e_drd;
      logic [31:0] e_drs;
      logic [15:0] e_imm;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic v, input logic [31:0] ins, input logic si);
      wb_we   = we;
      wb_addr = wa;
      wb_data = wd;
      valid_i = v;
      insn_i  = ins;
      stall_i = si;
   endtask

   initial begin
      //          we  wa     wd          v     insn          stl   vld   op     cc     rd     drd         drs         imm
      vecs[0]  = '{1'b1, 4'd3, 32'h0000_00A5, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 7'h00, 4'h0, 4'd0, 32'h0,  32'h0,  16'h0000};
      vecs[1]  = '{1'b0, 4'd0, 32'h0,         1'b1, 32'h0003_3000, 1'b0, 1'b1, 7'h00, 4'h0, 4'd3, 32'hA5, 32'hA5, 16'h3000};
      vecs[2]  = '{1'b0, 4'd0, 32'h0,         1'b1, 32'h0005_3000, 1'b1, 1'b0, 7'h00, 4'h0, 4'd0, 32'h0,  32'h0,  16'h0000};
      vecs[3]  = '{1'b1, 4'd3, 32'h0000_0055, 1'b1, 32'h0005_3000, 1'b0, 1'b1, 7'h00, 4'h0, 4'd5, 32'h0,  32'h55, 16'h3000};
      vecs[4]  = '{1'b0, 4'd0, 32'h0,         1'b1, 32'h0001_2000, 1'b0, 1'b1, 7'h00, 4'h0, 4'd1, 32'h0,  32'h0,  16'h2000};
      vecs[5]  = '{1'b0, 4'd0, 32'h0,         1'b1, 32'h0004_1000, 1'b1, 1'b0, 7'h00, 4'h0, 4'd0, 32'h0,  32'h0,  16'h0000};
      vecs[6]  = '{1'b0, 4'd0, 32'h0,         1'b1, 32'h0004_1000, 1'b1, 1'b0, 7'h00, 4'h0, 4'd0, 32'h0,  32'h0,  16'h0000};
      vecs[7]  = '{1'b1, 4'd1, 32'h0000_0010, 1'b1, 32'h0004_1000, 1'b0, 1'b1, 7'h00, 4'h0, 4'd4, 32'h0,  32'h10, 16'h1000};
      vecs[8]  = '{1'b0, 4'd0, 32'h0,         1'b1, 32'h01A6_5FFF, 1'b0, 1'b1, 7'h00, 4'hA, 4'd6, 32'h0,  32'h0,  16'h5FFF};
      vecs[9]  = '{1'b0, 4'd0, 32'h0,         1'b1, 32'h2137_FFFF, 1'b0, 1'b1, 7'h10, 4'h3, 4'd7, 32'h0,  32'h0,  16'hFFFF};
      vecs[10] = '{1'b1, 4'd2, 32'h0000_0022, 1'b1, 32'h0802_3000, 1'b0, 1'b1, 7'h04, 4'h0, 4'd2, 32'h22, 32'h55, 16'h3000};
      vecs[11] = '{1'b0, 4'd0, 32'h0,         1'b1, 32'h3203_2000, 1'b0, 1'b1, 7'h19, 4'h0, 4'd3, 32'h55, 32'h22, 16'h2000};
      vecs[12] = '{1'b0, 4'd0, 32'h0,         1'b1, 32'h0002_3000, 1'b0, 1'b1, 7'h00, 4'h0, 4'd2, 32'h22, 32'h55, 16'h3000};
      vecs[13] = '{1'b1, 4'd7, 32'h0000_0077, 1'b1, 32'h0007_0000, 1'b0, 1'b1, 7'h00, 4'h0, 4'd7, 32'h77, 32'h0,  16'h0000};
      vecs[14] = '{1'b0, 4'd0, 32'h0,         1'b1, 32'h0008_7000, 1'b1, 1'b0, 7'h00, 4'h0, 4'd0, 32'h0,  32'h0,  16'h0000};
      vecs[15] = '{1'b1, 4'd7, 32'h0000_0078, 1'b1, 32'h0008_7000, 1'b0, 1'b1, 7'h00, 4'h0, 4'd8, 32'h0,  32'h78, 16'h7000};
      vecs[16] = '{1'b0, 4'd0, 32'h0,         1'b1, 32'hFC08_8000, 1'b0, 1'b1, 7'h7E, 4'h0, 4'd8, 32'h0,  32'h0,  16'h8000};
      vecs[17] = '{1'b0, 4'd0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0, 7'h00, 4'h0, 4'd0, 32'h0,  32'h0,  16'h0000};

      rst = 1'b0;
      drive(1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset valid_o", {31'd0, valid_o}, 32'd0);
      chk("reset halted", {31'd0, halted}, 32'd0);
      chk("reset stall_o", {31'd0, stall_o}, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].v, vecs[i].insn, 1'b0);
         #2;
         chk($sformatf("v%0d stall_o", i), {31'd0, stall_o}, {31'd0, vecs[i].e_stall});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d valid_o", i), {31'd0, valid_o}, {31'd0, vecs[i].e_valid});
         chk($sformatf("v%0d halted", i), {31'd0, halted}, 32'd0);
         if (vecs[i].e_valid) begin
            chk($sformatf("v%0d opecode", i), {25'd0, opecode}, {25'd0, vecs[i].e_op});
            chk($sformatf("v%0d cc", i), {28'd0, cc}, {28'd0, vecs[i].e_cc});
            chk($sformatf("v%0d rd_addr", i), {28'd0, rd_addr}, {28'd0, vecs[i].e_rd});
            chk($sformatf("v%0d data_rd", i), data_rd, vecs[i].e_drd);
            chk($sformatf("v%0d data_rs", i), data_rs, vecs[i].e_drs);
            chk($sformatf("v%0d imm_ex", i), {16'd0, imm_ex}, {16'd0, vecs[i].e_imm});
         end
      end

      // Downstream stall holds the output register for three cycles.
      drive(1'b0, 4'd0, 32'h0, 1'b1, 32'h0009_A000, 1'b0);
      #2;
      chk("sa accept stall_o", {31'd0, stall_o}, 32'd0);
      @(posedge clk);
      #1;
      chk("sa valid_o", {31'd0, valid_o}, 32'd1);
      chk("sa rd_addr", {28'd0, rd_addr}, 32'd9);
      drive(1'b0, 4'd0, 32'h0, 1'b1, 32'h000B_C000, 1'b1);
      for (int k = 0; k < 3; k++) begin
         #2;
         chk($sformatf("sa hold%0d stall_o", k), {31'd0, stall_o}, 32'd1);
         @(posedge clk);
         #1;
         chk($sformatf("sa hold%0d valid_o", k), {31'd0, valid_o}, 32'd1);
         chk($sformatf("sa hold%0d rd_addr", k), {28'd0, rd_addr}, 32'd9);
         chk($sformatf("sa hold%0d imm_ex", k), {16'd0, imm_ex}, 32'h0000_A000);
      end
      drive(1'b0, 4'd0, 32'h0, 1'b1, 32'h000B_C000, 1'b0);
      #2;
      chk("sa release stall_o", {31'd0, stall_o}, 32'd0);
      @(posedge clk);
      #1;
      chk("sa release valid_o", {31'd0, valid_o}, 32'd1);
      chk("sa release rd_addr", {28'd0, rd_addr}, 32'd11);
      chk("sa release imm_ex", {16'd0, imm_ex}, 32'h0000_C000);

      // Halt is forwarded, then the stage refuses everything.
      drive(1'b0, 4'd0, 32'h0, 1'b1, 32'hFE00_0000, 1'b0);
      #2;
      chk("hlt accept stall_o", {31'd0, stall_o}, 32'd0);
      @(posedge clk);
      #1;
      chk("hlt valid_o", {31'd0, valid_o}, 32'd1);
      chk("hlt opecode", {25'd0, opecode}, 32'h7F);
      chk("hlt halted", {31'd0, halted}, 32'd1);
      drive(1'b0, 4'd0, 32'h0, 1'b1, 32'h000D_E000, 1'b0);
      #2;
      chk("hlt after stall_o", {31'd0, stall_o}, 32'd1);
      @(posedge clk);
      #1;
      chk("hlt after valid_o", {31'd0, valid_o}, 32'd0);
      chk("hlt after halted", {31'd0, halted}, 32'd1);
      #2;
      chk("hlt stuck stall_o", {31'd0, stall_o}, 32'd1);

      // Asynchronous reset between clock edges.
      #1;
      rst = 1'b0;
      #1;
      chk("arst valid_o", {31'd0, valid_o}, 32'd0);
      chk("arst halted", {31'd0, halted}, 32'd0);
      chk("arst stall_o", {31'd0, stall_o}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1'b0, 4'd0, 32'h0, 1'b1, 32'h0003_2000, 1'b0);
      #2;
      chk("post-rst stall_o", {31'd0, stall_o}, 32'd0);
      @(posedge clk);
      #1;
      chk("post-rst valid_o", {31'd0, valid_o}, 32'd1);
      chk("post-rst rd_addr", {28'd0, rd_addr}, 32'd3);
      chk("post-rst data_rd", data_rd, 32'd0);
      chk("post-rst data_rs", data_rs, 32'd0);
      drive(1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
